// File: rtl/dmem_lsu.sv
// Data memory with an RV32I load/store unit: one request at a time over valid/ready,
// byte-lane store alignment, load extension, fault detection and a registered response.
module dmem_lsu #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_RESP
   } state_e;

   state_e                state_q, state_d;
   logic [DEPTH_LOG2-1:0] rd_idx_q, rd_idx_d;
   logic [2:0]            ld_funct3_q, ld_funct3_d;
   logic [1:0]            ld_lane_q, ld_lane_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_fault_q, rsp_fault_d;

   logic [3:0][7:0] mem [DEPTH];

   logic                  accept;
   logic [1:0]            lane;
   logic [DEPTH_LOG2-1:0] widx;
   logic [31:0]           offset;
   logic                  in_range;
   logic                  funct3_ok;
   logic                  misaligned;
   logic                  fault;
   logic [3:0]            byte_en;
   logic [31:0]           wdata_rep;
   logic                  wr_en;

   logic [31:0] rd_word;
   logic [31:0] rd_shift;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] rd_ext;

   // Request decode; the 33-bit compare keeps the unsigned range check exact.
   always_comb begin
      accept     = req_valid && (state_q == S_IDLE);
      lane       = req_addr[1:0];
      widx       = req_addr[DEPTH_LOG2+1:2];
      offset     = req_addr - BASE_ADDR;
      in_range   = {1'b0, offset} < SPAN;
      funct3_ok  = 1'b0;
      misaligned = 1'b0;
      byte_en    = 4'b0000;
      wdata_rep  = req_wdata;

      case (req_funct3)
         3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
         3'b100, 3'b101:         funct3_ok = !req_we;
         default:                funct3_ok = 1'b0;
      endcase

      case (req_funct3[1:0])
         2'b01:   misaligned = lane[0];
         2'b10:   misaligned = (lane != 2'b00);
         default: misaligned = 1'b0;
      endcase

      case (req_funct3[1:0])
         2'b00: begin
            byte_en   = 4'b0001 << lane;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
         end
         default: begin
            byte_en   = 4'b1111;
            wdata_rep = req_wdata;
         end
      endcase

      fault = !funct3_ok || misaligned || !in_range;
      wr_en = accept && req_we && !fault;
   end

   always_comb begin
      rd_word  = mem[rd_idx_q];
      rd_shift = rd_word >> {ld_lane_q, 3'b000};
      rd_byte  = rd_shift[7:0];
      rd_half  = ld_lane_q[1] ? rd_word[31:16] : rd_word[15:0];
      case (ld_funct3_q)
         3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
         3'b010:  rd_ext = rd_word;
         3'b100:  rd_ext = {24'd0, rd_byte};
         3'b101:  rd_ext = {16'd0, rd_half};
         default: rd_ext = 32'd0;
      endcase
   end

   // Stores and faults skip RD; only a legal load latches a read address.
   always_comb begin
      state_d     = state_q;
      rd_idx_d    = rd_idx_q;
      ld_funct3_d = ld_funct3_q;
      ld_lane_d   = ld_lane_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_fault_d = rsp_fault_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               rsp_fault_d = fault;
               rsp_rdata_d = 32'd0;
               if (!req_we && !fault) begin
                  rd_idx_d    = widx;
                  ld_funct3_d = req_funct3;
                  ld_lane_d   = lane;
                  state_d     = S_RD;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_RD: begin
            rsp_rdata_d = rd_ext;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_rdata_d = 32'd0;
               rsp_fault_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rd_idx_q    <= '0;
         ld_funct3_q <= 3'd0;
         ld_lane_q   <= 2'd0;
         rsp_rdata_q <= 32'd0;
         rsp_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_idx_q    <= rd_idx_d;
         ld_funct3_q <= ld_funct3_d;
         ld_lane_q   <= ld_lane_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   // The array is never reset so a committed store survives rst_n.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[widx][i] <= wdata_rep[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: a byte-addressed memory model predicts every
// response, a negedge monitor compares outputs each cycle, directed loads pin literals.
module tb_dmem_lsu;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   int checks = 0;
   int errors = 0;

   // Expected response of the transaction in flight, written only just after a posedge
   bit          inTxn = 0;
   bit          freshReset = 1;
   logic [31:0] expRdata = 0;
   bit          expFault = 0;

   logic [7:0] modelBytes [4096];

   logic [31:0] got;
   bit          gotFault;

   dmem_lsu #(
      .DEPTH_LOG2(10),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_fault (rsp_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Spec-level model: byte-addressed little-endian memory, size from funct3
   task automatic modelAccess(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output bit f, output logic [31:0] rd);
      int          size;
      logic [31:0] off;
      logic [31:0] v;
      off = addr - 32'h0000_0000;
      case (f3)
         3'd0:    size = 1;
         3'd1:    size = 2;
         3'd2:    size = 4;
         3'd4:    size = we ? 0 : 1;
         3'd5:    size = we ? 0 : 2;
         default: size = 0;
      endcase
      rd = 32'd0;
      if (size == 0) f = 1'b1;
      else f = ((addr % size) != 0) || (off >= 32'd4096);
      if (!f) begin
         if (we) begin
            for (int i = 0; i < size; i++) modelBytes[off + i] = wd[8*i +: 8];
         end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(modelBytes[off + i]) << (8 * i));
            if (f3[2] == 1'b0 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
         end
      end
   endtask

   // Cycle monitor: reset values, response contents and req_ready exclusivity
   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("reset_rsp_valid", rsp_valid, 0);
         checkOutput("reset_req_ready", req_ready, 1);
         checkOutput("reset_rsp_rdata", rsp_rdata, 0);
         checkOutput("reset_rsp_fault", rsp_fault, 0);
      end else if (rsp_valid) begin
         checkOutput("rsp_expected", inTxn, 1);
         checkOutput("rsp_rdata", rsp_rdata, expRdata);
         checkOutput("rsp_fault", rsp_fault, expFault);
         checkOutput("ready_in_resp", req_ready, 0);
      end else if (!inTxn) begin
         checkOutput("idle_req_ready", req_ready, 1);
         if (freshReset) checkOutput("idle_rsp_rdata", rsp_rdata, 0);
      end
   end

   // One complete transaction; called at posedge+1 with the DUT idle
   task automatic applyStimulus(input string name, input bit we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd, input int hold,
                                output logic [31:0] rdOut, output bit faultOut);
      int expLat;
      int lat;
      bit mf;
      logic [31:0] md;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      rsp_ready  = (hold == 0);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = $urandom_range(0, 1);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      modelAccess(we, f3, addr, wd, mf, md);
      expFault   = mf;
      expRdata   = md;
      inTxn      = 1'b1;
      freshReset = 1'b0;
      expLat     = (!we && !mf) ? 1 : 0;
      lat        = 0;
      while (!rsp_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({name, "_latency"}, lat, expLat);
      rdOut    = rsp_rdata;
      faultOut = rsp_fault;
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         checkOutput({name, "_held_valid"}, rsp_valid, 1);
         checkOutput({name, "_held_rdata"}, rsp_rdata, expRdata);
         rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      checkOutput({name, "_rsp_done"}, rsp_valid, 0);
      checkOutput({name, "_ready_back"}, req_ready, 1);
      inTxn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 4096; i++) modelBytes[i] = 8'h00;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      rsp_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      $display("[TB] reset and idle done");

      for (int i = 0; i < 8; i++) applyStimulus("init_sw", 1, 3'd2, 32'(i * 4), 32'd0, 0, got, gotFault);

      applyStimulus("SW_10", 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, got, gotFault);
      checkOutput("SW_10_fault", gotFault, 0);
      applyStimulus("LW_10", 0, 3'd2, 32'h10, 32'h0, 0, got, gotFault);
      checkOutput("LW_10_lit", got, 32'hDEAD_BEEF);
      checkOutput("LW_10_fault", gotFault, 0);
      applyStimulus("LB_13", 0, 3'd0, 32'h13, 32'h0, 0, got, gotFault);
      checkOutput("LB_13_lit", got, 32'hFFFF_FFDE);
      applyStimulus("LBU_13", 0, 3'd4, 32'h13, 32'h0, 0, got, gotFault);
      checkOutput("LBU_13_lit", got, 32'h0000_00DE);
      applyStimulus("LH_12", 0, 3'd1, 32'h12, 32'h0, 0, got, gotFault);
      checkOutput("LH_12_lit", got, 32'hFFFF_DEAD);
      applyStimulus("LHU_10", 0, 3'd5, 32'h10, 32'h0, 0, got, gotFault);
      checkOutput("LHU_10_lit", got, 32'h0000_BEEF);
      applyStimulus("LB_10", 0, 3'd0, 32'h10, 32'h0, 0, got, gotFault);
      checkOutput("LB_10_lit", got, 32'hFFFF_FFEF);

      applyStimulus("SW_14", 1, 3'd2, 32'h14, 32'hCAFE_F00D, 0, got, gotFault);
      applyStimulus("SB_11", 1, 3'd0, 32'h11, 32'hAABB_CC55, 0, got, gotFault);
      applyStimulus("SH_12", 1, 3'd1, 32'h12, 32'h9999_1234, 0, got, gotFault);
      applyStimulus("LW_10b", 0, 3'd2, 32'h10, 32'h0, 0, got, gotFault);
      checkOutput("partial_lit", got, 32'h1234_55EF);
      applyStimulus("LW_14", 0, 3'd2, 32'h14, 32'h0, 0, got, gotFault);
      checkOutput("LW_14_lit", got, 32'hCAFE_F00D);
      applyStimulus("LW_0C", 0, 3'd2, 32'h0C, 32'h0, 0, got, gotFault);
      checkOutput("LW_0C_lit", got, 32'h0);

      applyStimulus("SW_FFC", 1, 3'd2, 32'hFFC, 32'h0123_4567, 0, got, gotFault);
      checkOutput("SW_FFC_fault", gotFault, 0);
      applyStimulus("LHU_FFE", 0, 3'd5, 32'hFFE, 32'h0, 0, got, gotFault);
      checkOutput("LHU_FFE_lit", got, 32'h0000_0123);

      applyStimulus("F_LW_2", 0, 3'd2, 32'h2, 32'h0, 0, got, gotFault);
      checkOutput("F_LW_2_fault", gotFault, 1);
      applyStimulus("F_SH_1", 1, 3'd1, 32'h1, 32'hFFFF_FFFF, 0, got, gotFault);
      checkOutput("F_SH_1_fault", gotFault, 1);
      applyStimulus("F_LD_011", 0, 3'd3, 32'h10, 32'h0, 0, got, gotFault);
      checkOutput("F_LD_011_fault", gotFault, 1);
      checkOutput("F_LD_011_rdata", got, 32'h0);
      applyStimulus("F_ST_011", 1, 3'd3, 32'h10, 32'hFFFF_FFFF, 0, got, gotFault);
      checkOutput("F_ST_011_fault", gotFault, 1);
      applyStimulus("F_ST_100", 1, 3'd4, 32'h10, 32'hFFFF_FFFF, 0, got, gotFault);
      checkOutput("F_ST_100_fault", gotFault, 1);
      applyStimulus("F_SW_1000", 1, 3'd2, 32'h1000, 32'hFFFF_FFFF, 0, got, gotFault);
      checkOutput("F_SW_1000_fault", gotFault, 1);
      applyStimulus("F_LW_1000", 0, 3'd2, 32'h1000, 32'h0, 0, got, gotFault);
      checkOutput("F_LW_1000_fault", gotFault, 1);
      applyStimulus("after_f_10", 0, 3'd2, 32'h10, 32'h0, 0, got, gotFault);
      checkOutput("after_f_10_lit", got, 32'h1234_55EF);
      applyStimulus("after_f_00", 0, 3'd2, 32'h0, 32'h0, 0, got, gotFault);
      checkOutput("after_f_00_lit", got, 32'h0);

      applyStimulus("bp_LW_14", 0, 3'd2, 32'h14, 32'h0, 5, got, gotFault);
      checkOutput("bp_LW_14_lit", got, 32'hCAFE_F00D);
      applyStimulus("bp_SW_1C", 1, 3'd2, 32'h1C, 32'h7777_0001, 5, got, gotFault);

      // Reset in the middle of a held store response
      rsp_ready  = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h18;
      req_wdata  = 32'hA5A5_A5A5;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      modelAccess(1'b1, 3'd2, 32'h18, 32'hA5A5_A5A5, expFault, expRdata);
      inTxn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("pre_reset_valid", rsp_valid, 1);
      inTxn = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_drops_valid", rsp_valid, 0);
      checkOutput("reset_ready", req_ready, 1);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready_after_release", req_ready, 1);
      applyStimulus("LW_18", 0, 3'd2, 32'h18, 32'h0, 0, got, gotFault);
      checkOutput("LW_18_lit", got, 32'hA5A5_A5A5);
      applyStimulus("LW_1C", 0, 3'd2, 32'h1C, 32'h0, 0, got, gotFault);
      checkOutput("LW_1C_lit", got, 32'h7777_0001);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
